jts16_trackball_mux: RTL and testbench
======================================

Name: jts16_trackball_mux

Overview:
- Parametrised trackball/analogue-stick emulator for Sega System 16 class cores.
- Converts signed 8-bit analogue samples and optional digital directions into CH free-running position counters, updated once per DIV horizontal blanks.
- Updates use one time-shared adder that walks the channels sequentially.
- Adds dead zone, gain shift, per-channel inversion, saturate/wrap mode, and a coherent CPU snapshot read port.

Parameters:
CH, 8, number of counter channels (2 per player: X, Y); min 1.
W, 12, counter width in bits.
DIV, 64, LHBL falling edges per update period; min 1.
SHIFT, 3, arithmetic right shift applied to analogue sample (gain); 0..7.
DEAD, 0, dead-zone magnitude; samples with |s| <= DEAD count as zero.
DIGSTEP, 4, step magnitude for digital inputs.
SAT, 0, 1 = clamp counters to 0..2^W-1; 0 = wrap modulo 2^W.
INIT, 12'h100, reset value of every counter and snapshot entry (W bits).

Ports:
clk      in   1        system clock
rst      in   1        asynchronous, active-low reset
LHBL     in   1        horizontal blank, active low
en       in   1        0 = updates suppressed (divider still counts)
joyana   in   CH*8     signed 8-bit sample per channel, channel k at [8k+7:8k]
dig_inc  in   CH       digital increment request per channel
dig_dec  in   CH       digital decrement request per channel
inv      in   CH       1 = negate channel step
latch    in   1        one-cycle pulse: request snapshot of all counters
sel      in   clog2(CH) snapshot channel select (width 1 when CH=1)
dout     out  W        registered snapshot[sel]
busy     out  1        update sequence in progress
tb_live  out  CH*W     live counters, channel k at [Wk+W-1:Wk]

Behaviour:
- Reset (rst low, asynchronous):
  - counters = INIT, snapshot = INIT, dout = 0, busy = 0.
  - divider = 0; pending flags cleared; LHBL edge register = 1.
  - Takes effect immediately, including mid-update; no partial writes survive.
- Edge detect:
  - LHBL registered each clk; a falling edge is LHBL_q=1 and LHBL=0.
  - Each edge increments the divider, which wraps at DIV-1.
  - An edge arriving with divider==0 raises an update request. So the first edge after reset updates, then every DIV-th edge.
- Update request handling:
  - If en=0, the request is dropped.
  - If busy, the request sets upd_pend and starts one cycle after the current sequence ends. At most one request is pending; extras are dropped.
- FSM:
  - IDLE: update request -> RUN, idx = 0, busy = 1.
  - RUN: one channel per clk; writes counter[idx]; idx++.
  - After idx = CH-1 -> DONE, busy still 1.
  - DONE: 1 cycle; services a pending snapshot; -> IDLE with busy = 0, or -> RUN if upd_pend.
  - Sequence length is CH+1 cycles from entry to RUN until busy falls.
- Step computation for channel k, sample s:
  - If |s| > DEAD: a = s >>> SHIFT, an arithmetic shift rounding toward minus infinity, so -1 gives -1.
  - Otherwise a = 0.
  - If a == 0 and dig_inc xor dig_dec: d = +DIGSTEP if dig_inc, -DIGSTEP if dig_dec. Otherwise d = a.
  - step = inv[k] ? -d : d, sign-extended to W+1 bits.
  - s = -128 (0x80) is legal: |s| = 128 and a = -128 >>> SHIFT.
- Counter write:
  - sum = counter + step, computed in W+1 signed arithmetic.
  - SAT=0: counter = sum mod 2^W.
  - SAT=1: sum < 0 -> 0; sum > 2^W-1 -> 2^W-1; otherwise sum.
- Inputs are sampled during the channel's own RUN cycle.
- Snapshot:
  - latch in IDLE with no update starting: snapshot = all counters on the next edge.
  - latch in the same cycle an update request starts RUN: snapshot takes the pre-update values.
  - latch while busy: snap_pend is set and the snapshot is taken in DONE with post-update values.
- dout = snapshot[sel], registered, 1-cycle latency.
- sel >= CH returns 0.
- tb_live reflects counters combinationally from their registers.

Test Plan:
1. Reset with defaults -> all tb_live channels 0x100, dout 0, busy 0; rst pulse mid-RUN -> same values on the next clk, busy 0.
2. joyana[0] = 0x40 (+64), first LHBL fall -> busy high 9 cycles, ch0 = 0x108. Falls 2..64 leave ch0 unchanged. Fall 65 gives 0x110.
3. joyana[1] = 0xC0 (-64) with inv[1] = 1 -> ch1 += 8. Sample 0xFF -> ch1 -= 1. With DEAD = 2, 0xFF -> no change.
4. Counter 0x000 with step -8: SAT=0 -> 0xFF8, SAT=1 -> 0x000. Counter 0xFFC with step +8 and SAT=1 -> 0xFFF.
5. latch pulsed on the 3rd RUN cycle with ch0 step +8 -> dout (sel=0) reads 0x108, not 0x100, once busy falls. latch in IDLE -> dout updates 2 clks later.
6. joyana = 0, dig_inc[2] = 1 -> ch2 += 4 per update; dig_inc[2] and dig_dec[2] both high -> no change; en = 0 -> no counter changes over 3 periods.

Source files
------------

// File: rtl/jts16_trackball_mux.sv
// Trackball / analogue-stick position counters for System 16 cores.
// One shared adder walks the channels once per DIV line blanks; snapshots give the CPU a coherent read.
module jts16_trackball_mux #(
  parameter int          CH      = 8,
  parameter int          W       = 12,
  parameter int          DIV     = 64,
  parameter int          SHIFT   = 3,
  parameter int          DEAD    = 0,
  parameter int          DIGSTEP = 4,
  parameter int          SAT     = 0,
  parameter logic [W-1:0] INIT   = 'h100,
  localparam int         IW      = (CH > 1) ? $clog2(CH) : 1,
  localparam int         DW      = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            LHBL,
  input  logic            en,
  input  logic [CH*8-1:0] joyana,
  input  logic [CH-1:0]   dig_inc,
  input  logic [CH-1:0]   dig_dec,
  input  logic [CH-1:0]   inv,
  input  logic            latch,
  input  logic [IW-1:0]   sel,
  output logic [W-1:0]    dout,
  output logic            busy,
  output logic [CH*W-1:0] tb_live
);

  localparam int MAXV = (1 << W) - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        div_q;
  logic                 lhbl_q;
  logic                 upd_pend_q, upd_pend_d;
  logic                 snap_pend_q, snap_pend_d;
  logic [CH-1:0][W-1:0] cnt_q, snap_q;
  logic [W-1:0]         cnt_d, dout_q;
  logic                 fall, req, snap_now;
  logic [7:0]           smp;
  int                   s_i, mag_i, a_i, d_i, sum_i;

  assign fall    = lhbl_q & ~LHBL;
  assign req     = fall & (div_q == '0) & en;
  assign busy    = (state_q != IDLE);
  assign dout    = dout_q;
  assign tb_live = cnt_q;

  // The divider keeps counting with en low so the update phase never drifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lhbl_q <= 1'b1;
      div_q  <= '0;
    end else begin
      lhbl_q <= LHBL;
      if (fall) div_q <= (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    upd_pend_d  = upd_pend_q;
    snap_pend_d = snap_pend_q;
    snap_now    = 1'b0;
    case (state_q)
      IDLE: begin
        // Counters are not written until RUN, so a latch here sees pre-update values.
        snap_now = latch;
        if (req || upd_pend_q) begin
          state_d    = RUN;
          idx_d      = '0;
          upd_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (req)   upd_pend_d  = 1'b1;
        if (latch) snap_pend_d = 1'b1;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(CH - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        snap_now    = snap_pend_q | latch;
        snap_pend_d = 1'b0;
        if (req) upd_pend_d = 1'b1;
        if (upd_pend_q) begin
          state_d    = RUN;
          idx_d      = '0;
          upd_pend_d = req;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared step/adder for the channel addressed by idx_q.
  always_comb begin
    smp   = joyana[{idx_q, 3'b000} +: 8];
    s_i   = int'($signed(smp));
    mag_i = (s_i < 0) ? -s_i : s_i;
    a_i   = (mag_i > DEAD) ? (s_i >>> SHIFT) : 0;
    d_i   = a_i;
    if (a_i == 0 && (dig_inc[idx_q] ^ dig_dec[idx_q]))
      d_i = dig_inc[idx_q] ? DIGSTEP : -DIGSTEP;
    if (inv[idx_q]) d_i = -d_i;
    sum_i = int'(cnt_q[idx_q]) + d_i;
    cnt_d = W'(sum_i);
    if (SAT != 0) begin
      if (sum_i < 0)         cnt_d = '0;
      else if (sum_i > MAXV) cnt_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      upd_pend_q  <= 1'b0;
      snap_pend_q <= 1'b0;
      cnt_q       <= {CH{INIT}};
      snap_q      <= {CH{INIT}};
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      upd_pend_q  <= upd_pend_d;
      snap_pend_q <= snap_pend_d;
      if (state_q == RUN) cnt_q[idx_q] <= cnt_d;
      if (snap_now)       snap_q <= cnt_q;
      dout_q <= (int'(sel) < CH) ? snap_q[sel] : '0;
    end
  end

endmodule

// File: tb/tb_jts16_trackball_mux.sv
// Directed bench for jts16_trackball_mux: default instance plus small SAT/wrap/CH=1 variants.
module tb_jts16_trackball_mux;

  logic        clk = 0, rst = 0, LHBL = 1, en = 1, latch = 0;
  logic [63:0] joyana = '0;
  logic [7:0]  dig_inc = '0, dig_dec = '0, inv = '0;
  logic [2:0]  sel = '0;
  logic [11:0] dout;
  logic        busy;
  logic [95:0] tb_live;

  logic        lhbl2 = 1, latch2 = 0, sel2 = 0, latch3 = 0, sel3 = 0;
  logic [15:0] joy2 = '0;
  logic [1:0]  z2 = '0;
  logic [7:0]  joy3 = '0;
  logic        z1 = 0;
  logic [11:0] dout_s0, dout_s1, dout_s2, live_s2;
  logic        busy_s0, busy_s1, busy_s2;
  logic [23:0] live_s0, live_s1;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  jts16_trackball_mux u_dut (
    .clk(clk), .rst(rst), .LHBL(LHBL), .en(en), .joyana(joyana), .dig_inc(dig_inc),
    .dig_dec(dig_dec), .inv(inv), .latch(latch), .sel(sel), .dout(dout), .busy(busy),
    .tb_live(tb_live));

  jts16_trackball_mux #(.CH(2), .DIV(1), .SAT(0), .INIT(12'h000)) u_s0 (
    .clk(clk), .rst(rst), .LHBL(lhbl2), .en(en), .joyana(joy2), .dig_inc(z2),
    .dig_dec(z2), .inv(z2), .latch(latch2), .sel(sel2), .dout(dout_s0), .busy(busy_s0),
    .tb_live(live_s0));

  jts16_trackball_mux #(.CH(2), .DIV(1), .SAT(1), .DEAD(2), .INIT(12'h000)) u_s1 (
    .clk(clk), .rst(rst), .LHBL(lhbl2), .en(en), .joyana(joy2), .dig_inc(z2),
    .dig_dec(z2), .inv(z2), .latch(latch2), .sel(sel2), .dout(dout_s1), .busy(busy_s1),
    .tb_live(live_s1));

  jts16_trackball_mux #(.CH(1), .DIV(1), .SAT(1), .INIT(12'hFFC)) u_s2 (
    .clk(clk), .rst(rst), .LHBL(lhbl2), .en(en), .joyana(joy3), .dig_inc(z1),
    .dig_dec(z1), .inv(z1), .latch(latch3), .sel(sel3), .dout(dout_s2), .busy(busy_s2),
    .tb_live(live_s2));

  function automatic logic [11:0] live(input int k);
    return tb_live[k*12 +: 12];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fall();
    LHBL = 0; tick(); LHBL = 1; tick();
  endtask

  task automatic fall2();
    lhbl2 = 0; tick(); lhbl2 = 1; repeat (5) tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle timeout: busy=%b after %0d cycles, need 0", busy, n);
    end
  endtask

  // 64 falls; the last one lands on divider 0 and triggers an update.
  task automatic period();
    repeat (64) fall();
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 0; repeat (2) tick();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (live(k) !== 12'h100) begin n_bad++; $display("FAIL reset_live ch%0d act=%h exp=100", k, live(k)); end
    end
    n_cmp++; if (dout !== 12'h000) begin n_bad++; $display("FAIL reset_dout act=%h exp=000", dout); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy act=%b exp=0", busy); end
    rst = 1; tick();
    joyana[7:0] = 8'h40;
    LHBL = 0; tick(); LHBL = 1; tick(); tick();
    n_cmp++; if (live(0) !== 12'h108) begin n_bad++; $display("FAIL midrun_ch0 act=%h exp=108", live(0)); end
    rst = 0; #1;
    n_cmp++; if (live(0) !== 12'h100 || busy !== 1'b0) begin n_bad++; $display("FAIL async_rst act=%h/%b exp=100/0", live(0), busy); end
    tick();
    n_cmp++; if (live(0) !== 12'h100 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_next_clk act=%h/%b exp=100/0", live(0), busy); end
    rst = 1; tick();
  endtask

  task automatic test_first_update();
    int n = 0;
    LHBL = 0; tick(); LHBL = 1;
    while (busy && n < 20) begin n++; tick(); end
    n_cmp++; if (n != 9) begin n_bad++; $display("FAIL busy_len act=%0d exp=9", n); end
    n_cmp++; if (live(0) !== 12'h108) begin n_bad++; $display("FAIL first_upd act=%h exp=108", live(0)); end
    repeat (63) fall();
    n_cmp++; if (live(0) !== 12'h108) begin n_bad++; $display("FAIL div_hold act=%h exp=108", live(0)); end
    fall(); wait_idle();
    n_cmp++; if (live(0) !== 12'h110) begin n_bad++; $display("FAIL fall65 act=%h exp=110", live(0)); end
    n_cmp++; if (live(1) !== 12'h100) begin n_bad++; $display("FAIL ch1_idle act=%h exp=100", live(1)); end
  endtask

  task automatic test_inv_neg();
    joyana = '0; joyana[15:8] = 8'hC0; inv[1] = 1;
    period();
    n_cmp++; if (live(1) !== 12'h108) begin n_bad++; $display("FAIL inv_neg act=%h exp=108", live(1)); end
    n_cmp++; if (live(0) !== 12'h110) begin n_bad++; $display("FAIL ch0_zero act=%h exp=110", live(0)); end
    joyana[15:8] = 8'hFF; inv = '0;
    period();
    n_cmp++; if (live(1) !== 12'h107) begin n_bad++; $display("FAIL minus1_shift act=%h exp=107", live(1)); end
  endtask

  task automatic test_sat();
    joy2 = {8'hFF, 8'hC0}; joy3 = 8'h40;
    fall2();
    n_cmp++; if (live_s0[11:0]  !== 12'hFF8) begin n_bad++; $display("FAIL wrap_lo act=%h exp=ff8", live_s0[11:0]); end
    n_cmp++; if (live_s0[23:12] !== 12'hFFF) begin n_bad++; $display("FAIL wrap_m1 act=%h exp=fff", live_s0[23:12]); end
    n_cmp++; if (live_s1[11:0]  !== 12'h000) begin n_bad++; $display("FAIL sat_lo act=%h exp=000", live_s1[11:0]); end
    n_cmp++; if (live_s1[23:12] !== 12'h000) begin n_bad++; $display("FAIL dead_zone act=%h exp=000", live_s1[23:12]); end
    n_cmp++; if (live_s2 !== 12'hFFF) begin n_bad++; $display("FAIL sat_hi act=%h exp=fff", live_s2); end
    joy2 = {8'h80, 8'h7F};
    fall2();
    n_cmp++; if (live_s0[11:0]  !== 12'h007) begin n_bad++; $display("FAIL wrap_up act=%h exp=007", live_s0[11:0]); end
    n_cmp++; if (live_s0[23:12] !== 12'hFEF) begin n_bad++; $display("FAIL neg128 act=%h exp=fef", live_s0[23:12]); end
    n_cmp++; if (live_s1[11:0]  !== 12'h00F) begin n_bad++; $display("FAIL sat_pos act=%h exp=00f", live_s1[11:0]); end
    n_cmp++; if (live_s1[23:12] !== 12'h000) begin n_bad++; $display("FAIL sat_neg128 act=%h exp=000", live_s1[23:12]); end
    n_cmp++; if (live_s2 !== 12'hFFF) begin n_bad++; $display("FAIL sat_hold act=%h exp=fff", live_s2); end
    latch3 = 1; tick(); latch3 = 0; tick();
    n_cmp++; if (dout_s2 !== 12'hFFF) begin n_bad++; $display("FAIL ch1_snap act=%h exp=fff", dout_s2); end
    sel3 = 1; tick();
    n_cmp++; if (dout_s2 !== 12'h000) begin n_bad++; $display("FAIL sel_range act=%h exp=000", dout_s2); end
  endtask

  task automatic test_snapshot();
    joyana = '0; joyana[7:0] = 8'h40; sel = 0;
    tick();
    n_cmp++; if (dout !== 12'h100) begin n_bad++; $display("FAIL snap_init act=%h exp=100", dout); end
    repeat (63) fall();
    LHBL = 0; tick(); LHBL = 1; tick(); tick();
    latch = 1; tick(); latch = 0;
    wait_idle();
    n_cmp++; if (dout !== 12'h100) begin n_bad++; $display("FAIL snap_lat act=%h exp=100", dout); end
    tick();
    n_cmp++; if (dout !== 12'h118) begin n_bad++; $display("FAIL snap_busy act=%h exp=118", dout); end
  endtask

  task automatic test_digital();
    joyana = '0; dig_inc[2] = 1;
    period();
    n_cmp++; if (live(2) !== 12'h104) begin n_bad++; $display("FAIL dig_inc act=%h exp=104", live(2)); end
    sel = 2; tick();
    latch = 1; tick(); latch = 0;
    n_cmp++; if (dout !== 12'h100) begin n_bad++; $display("FAIL idle_latch_1clk act=%h exp=100", dout); end
    tick();
    n_cmp++; if (dout !== 12'h104) begin n_bad++; $display("FAIL idle_latch_2clk act=%h exp=104", dout); end
    dig_dec[2] = 1;
    period();
    n_cmp++; if (live(2) !== 12'h104) begin n_bad++; $display("FAIL dig_both act=%h exp=104", live(2)); end
    dig_inc = '0; dig_dec = '0;
    en = 0; joyana[7:0] = 8'h40;
    repeat (3) period();
    n_cmp++; if (live(0) !== 12'h118 || busy !== 1'b0) begin n_bad++; $display("FAIL en_off act=%h/%b exp=118/0", live(0), busy); end
    en = 1;
    period();
    n_cmp++; if (live(0) !== 12'h120) begin n_bad++; $display("FAIL en_phase act=%h exp=120", live(0)); end
  endtask

  initial begin
    test_reset();
    test_first_update();
    test_inv_neg();
    test_sat();
    test_snapshot();
    test_digital();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
